ucsbece154b_branch_resolve: RTL and testbench
=============================================

UCSBECE154B_BRANCH_RESOLVE -- requirements
Module: ucsbece154b_branch_resolve

Interface
REQ-001 SHALL have parameter NUM_BTB_ENTRIES, default 32, the BTB entry count; BTB index width IW = $clog2(NUM_BTB_ENTRIES).
REQ-002 SHALL have parameter NUM_GHR_BITS, default 5, the PHT address width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_i  input  1  synchronous active-high reset.
REQ-006 pc_f_i  input  32  fetch PC.
REQ-007 branch_taken_f_i  input  1  predictor taken prediction for pc_f_i.
REQ-008 btb_target_f_i  input  32  predicted target for pc_f_i.
REQ-009 pht_addr_f_i  input  NUM_GHR_BITS  PHT read address used for pc_f_i.
REQ-010 stall_d_i  input  1  hazard stall of decode stage.
REQ-011 op_e_i  input  7  opcode of instruction in execute.
REQ-012 cond_e_i  input  1  resolved branch condition in execute.
REQ-013 target_e_i  input  32  computed target in execute.
REQ-014 mispredict_o  output  1  redirect request, flushes F/D.
REQ-015 redirect_pc_o  output  32  correct next PC.
REQ-016 BTB_we_o  output  1; BTBwriteaddress_o  output  IW; BTBwritedata_o  output  32; pc_update_o  output  32  BTB write port.
REQ-017 PHTwe_o  output  1; PHTincrement_o  output  1; PHTwriteaddress_o  output  NUM_GHR_BITS  PHT update port.
REQ-018 GHRreset_o  output  1  GHR recovery pulse.

Function
REQ-019 SHALL hold two tracking registers D and E, each {valid, pc, pred_taken, pred_target, pht_addr}.
REQ-020 Each cycle, absent stall/flush: D <= {1, F inputs}; E <= D.
REQ-021 stall_d_i=1: D holds; E loads bubble (valid=0).
REQ-022 mispredict_o=1: D and E both load valid=0 next edge, overriding stall_d_i.
REQ-023 ctrl = E.valid and op_e_i in {branch, jal, jalr}; actual = jal/jalr ? 1 : branch ? cond_e_i : 0.
REQ-024 mispredict_o (combinational) = E.valid and (E.pred_taken != actual or (actual and E.pred_target != target_e_i)); covers non-control instruction predicted taken.
REQ-025 redirect_pc_o = actual ? target_e_i : E.pc + 4 (32-bit wrap); 0 when mispredict_o=0.
REQ-026 BTB_we_o = ctrl and actual and (!E.pred_taken or E.pred_target != target_e_i); BTBwriteaddress_o = E.pc[IW+1:2]; BTBwritedata_o = target_e_i; pc_update_o = E.pc.
REQ-027 PHTwe_o = E.valid and op_e_i==branch; PHTincrement_o = cond_e_i; PHTwriteaddress_o = E.pht_addr.
REQ-028 GHRreset_o = mispredict_o on a branch; single-cycle per event.
REQ-029 All update outputs SHALL be 0 when E.valid=0; bubbles never update predictor state.
REQ-030 Back-to-back mispredicts impossible: instruction after a mispredict is always a bubble.

Reset
REQ-031 reset_i=1: D.valid, E.valid <= 0, other fields <= 0; all outputs 0 in the cycle after reset.
REQ-032 Reset mid-operation discards in-flight predictions; no update emitted for them.

Configuration
REQ-033 Macro BRANCH_STATS_EN defined: 32-bit saturating counters stat_branches_o (increments on PHTwe_o) and stat_mispredicts_o (increments on mispredict_o) exist as outputs, cleared by reset_i.
REQ-034 Macro undefined: counters and ports absent; all other behaviour identical.

Verification
REQ-035 Branch pc 0x100 predicted not-taken, cond=1, target 0x80 -> mispredict_o=1, redirect 0x80, BTB_we_o=1 addr 0, PHTinc=1, GHRreset_o=1.
REQ-036 Branch predicted taken to 0x80, cond=1, target 0x80 -> mispredict_o=0, BTB_we_o=0, PHTwe_o=1 inc=1.
REQ-037 Branch pc 0x200 predicted taken, cond=0 -> mispredict_o=1, redirect 0x204, BTB_we_o=0, PHTinc=0.
REQ-038 jal pc 0x40 predicted taken target 0x10, actual 0x20 -> mispredict, redirect 0x20, BTB_we_o=1 data 0x20, PHTwe_o=0.
REQ-039 stall_d_i=1 two cycles -> E bubbles, no updates; D released unchanged; mispredict during stall clears D.
REQ-040 reset_i asserted with branch in E -> next cycle all outputs 0, no PHT/BTB write.

Source files
------------

// File: rtl/ucsbece154b_branch_resolve_if.sv
// ucsbece154b_branch_resolve_if: fetch/decode/execute-side signals of the branch resolver, grouped.
// master: pipeline side, drives the F/D/E inputs and observes redirect/predictor-update outputs.
// slave:  resolver side (ucsbece154b_branch_resolve).
interface ucsbece154b_branch_resolve_if #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
);
    localparam int IW = $clog2(NUM_BTB_ENTRIES);
    logic [31:0]             pc_f_i;
    logic                    branch_taken_f_i;
    logic [31:0]             btb_target_f_i;
    logic [NUM_GHR_BITS-1:0] pht_addr_f_i;
    logic                    stall_d_i;
    logic [6:0]              op_e_i;
    logic                    cond_e_i;
    logic [31:0]             target_e_i;
    logic                    mispredict_o;
    logic [31:0]             redirect_pc_o;
    logic                    BTB_we_o;
    logic [IW-1:0]           BTBwriteaddress_o;
    logic [31:0]             BTBwritedata_o;
    logic [31:0]             pc_update_o;
    logic                    PHTwe_o;
    logic                    PHTincrement_o;
    logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
    logic                    GHRreset_o;
    modport master (
        output pc_f_i, branch_taken_f_i, btb_target_f_i, pht_addr_f_i, stall_d_i,
               op_e_i, cond_e_i, target_e_i,
        input  mispredict_o, redirect_pc_o, BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
               pc_update_o, PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o
    );
    modport slave (
        input  pc_f_i, branch_taken_f_i, btb_target_f_i, pht_addr_f_i, stall_d_i,
               op_e_i, cond_e_i, target_e_i,
        output mispredict_o, redirect_pc_o, BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
               pc_update_o, PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o
    );
endinterface

// File: rtl/ucsbece154b_branch_resolve.sv
// ucsbece154b_branch_resolve: tracks fetch-time predictions through D/E and resolves them in execute.
// Ports: clk, reset_i (sync, active-high); bus (slave modport) carries fetch prediction, decode stall,
// execute opcode/condition/target in, and redirect, BTB write, PHT update and GHR recovery out.
// Optional macro BRANCH_STATS_EN adds saturating stat_branches_o / stat_mispredicts_o counters.
module ucsbece154b_branch_resolve #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic clk,
    input  logic reset_i,
    ucsbece154b_branch_resolve_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches_o,
    output logic [31:0] stat_mispredicts_o
`endif
);
    localparam int IW = $clog2(NUM_BTB_ENTRIES);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    typedef struct packed {
        logic                    valid;
        logic [31:0]             pc;
        logic                    pred_taken;
        logic [31:0]             pred_target;
        logic [NUM_GHR_BITS-1:0] pht_addr;
    } track_t;
    track_t d_q, d_d, e_q, e_d;
    logic   is_br, is_jump, actual, mispredict;
    always_comb begin
        is_br      = e_q.valid && bus.op_e_i == OP_BRANCH;
        is_jump    = e_q.valid && (bus.op_e_i == OP_JAL || bus.op_e_i == OP_JALR);
        actual     = is_jump || (is_br && bus.cond_e_i);
        mispredict = e_q.valid && (e_q.pred_taken != actual ||
                     (actual && e_q.pred_target != bus.target_e_i));
        d_d = mispredict ? '0 : bus.stall_d_i ? d_q :
              track_t'{valid: 1'b1, pc: bus.pc_f_i, pred_taken: bus.branch_taken_f_i,
                       pred_target: bus.btb_target_f_i, pht_addr: bus.pht_addr_f_i};
        e_d = (mispredict || bus.stall_d_i) ? '0 : d_q;
    end
    always_ff @(posedge clk) begin
        if (reset_i) begin
            d_q <= '0;
            e_q <= '0;
        end else begin
            d_q <= d_d;
            e_q <= e_d;
        end
    end
    // Every bubble is loaded as all-zero, so E's pc/pht_addr fields already read 0 when invalid.
    assign bus.mispredict_o      = mispredict;
    assign bus.redirect_pc_o     = mispredict ? (actual ? bus.target_e_i : e_q.pc + 32'd4) : '0;
    assign bus.BTB_we_o          = actual && (!e_q.pred_taken || e_q.pred_target != bus.target_e_i);
    assign bus.BTBwriteaddress_o = e_q.pc[IW+1:2];
    assign bus.BTBwritedata_o    = e_q.valid ? bus.target_e_i : '0;
    assign bus.pc_update_o       = e_q.pc;
    assign bus.PHTwe_o           = is_br;
    assign bus.PHTincrement_o    = e_q.valid && bus.cond_e_i;
    assign bus.PHTwriteaddress_o = e_q.pht_addr;
    assign bus.GHRreset_o        = mispredict && is_br;
`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset_i) begin
            stat_branches_o    <= '0;
            stat_mispredicts_o <= '0;
        end else begin
            if (is_br && stat_branches_o != '1) stat_branches_o <= stat_branches_o + 32'd1;
            if (mispredict && stat_mispredicts_o != '1) stat_mispredicts_o <= stat_mispredicts_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// tb_ucsbece154b_branch_resolve: directed bench with an instruction-level model of the resolver.
module tb_ucsbece154b_branch_resolve;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, ALU = 7'b0110011;
    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic [4:0]  pha;
        logic [6:0]  op;
        logic        cond;
        logic [31:0] tgt;
    } ins_t;
    typedef struct {
        logic        mis;
        logic [31:0] redir;
        logic        btbwe;
        logic [4:0]  btba;
        logic [31:0] btbd;
        logic [31:0] pcu;
        logic        phtwe;
        logic        phtinc;
        logic [4:0]  phta;
        logic        ghr;
    } exp_t;
    logic clk = 1'b0;
    logic reset_i;
    int checks = 0, errors = 0;
    bit chk_en = 0;
    bit m_dv = 0, m_ev = 0;
    ins_t m_d, m_e, cur_f;
    bit cur_stall = 0, cur_rst = 1;
    always #5 clk = ~clk;
    ucsbece154b_branch_resolve_if #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) b();
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_b, stat_m;
    int m_nb = 0, m_nm = 0;
`endif
    ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
        .clk(clk), .reset_i(reset_i), .bus(b)
`ifdef BRANCH_STATS_EN
        , .stat_branches_o(stat_b), .stat_mispredicts_o(stat_m)
`endif
    );
    function automatic ins_t mk(logic [31:0] pc, logic pt, logic [31:0] ptgt, logic [4:0] pha,
                                logic [6:0] op, logic cond, logic [31:0] tgt);
        ins_t r;
        r.pc = pc; r.pt = pt; r.ptgt = ptgt; r.pha = pha; r.op = op; r.cond = cond; r.tgt = tgt;
        return r;
    endfunction
    function automatic ins_t nop(logic [31:0] pc);
        return mk(pc, 1'b0, 32'h0, 5'h0, ALU, 1'b0, 32'h0);
    endfunction
    // What the resolver must report for the instruction occupying execute.
    function automatic exp_t model(bit v, ins_t i);
        exp_t r;
        bit br, taken, steered_right;
        r = '{default: 0};
        if (!v) return r;
        br            = i.op == BR;
        taken         = i.op == JAL || i.op == JALR || (br && i.cond);
        steered_right = i.pt && i.ptgt == i.tgt;
        r.mis    = taken ? !steered_right : i.pt;
        r.redir  = !r.mis ? 32'h0 : taken ? i.tgt : i.pc + 32'd4;
        r.btbwe  = taken && !steered_right;
        r.btba   = 5'((i.pc >> 2) % 32);
        r.btbd   = i.tgt;
        r.pcu    = i.pc;
        r.phtwe  = br;
        r.phtinc = i.cond;
        r.phta   = i.pha;
        r.ghr    = r.mis && br;
        return r;
    endfunction
    task automatic cmp(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
        end
    endtask
    task automatic drive();
        reset_i = cur_rst;
        b.pc_f_i = cur_f.pc; b.branch_taken_f_i = cur_f.pt; b.btb_target_f_i = cur_f.ptgt;
        b.pht_addr_f_i = cur_f.pha; b.stall_d_i = cur_stall;
        if (m_ev) begin
            b.op_e_i = m_e.op; b.cond_e_i = m_e.cond; b.target_e_i = m_e.tgt;
        end else begin
            b.op_e_i = BR; b.cond_e_i = 1'b1; b.target_e_i = 32'hDEAD0000;
        end
    endtask
    // Advance one cycle: retire the model's view of the edge, then present the next inputs.
    task automatic step(ins_t f, bit stall, bit rst);
        exp_t x;
        @(posedge clk);
        #1;
        x = model(m_ev, m_e);
`ifdef BRANCH_STATS_EN
        if (cur_rst) begin m_nb = 0; m_nm = 0; end
        else begin m_nb += int'(x.phtwe); m_nm += int'(x.mis); end
`endif
        if (cur_rst || x.mis) begin
            m_dv = 0; m_ev = 0;
        end else if (cur_stall) begin
            m_ev = 0;
        end else begin
            m_ev = m_dv; m_e = m_d; m_dv = 1; m_d = cur_f;
        end
        cur_f = f; cur_stall = stall; cur_rst = rst;
        drive();
        chk_en = 1;
        @(negedge clk);
    endtask
    task automatic run3(ins_t x);
        step(x, 0, 0);
        step(nop(32'h1000), 0, 0);
        step(nop(32'h1004), 0, 0);
    endtask
    always @(negedge clk) begin
        exp_t x;
        if (chk_en) begin
            x = model(m_ev, m_e);
            cmp("mispredict_o", 32'(b.mispredict_o), 32'(x.mis));
            cmp("redirect_pc_o", b.redirect_pc_o, x.redir);
            cmp("BTB_we_o", 32'(b.BTB_we_o), 32'(x.btbwe));
            cmp("BTBwriteaddress_o", 32'(b.BTBwriteaddress_o), 32'(x.btba));
            cmp("BTBwritedata_o", b.BTBwritedata_o, x.btbd);
            cmp("pc_update_o", b.pc_update_o, x.pcu);
            cmp("PHTwe_o", 32'(b.PHTwe_o), 32'(x.phtwe));
            cmp("PHTincrement_o", 32'(b.PHTincrement_o), 32'(x.phtinc));
            cmp("PHTwriteaddress_o", 32'(b.PHTwriteaddress_o), 32'(x.phta));
            cmp("GHRreset_o", 32'(b.GHRreset_o), 32'(x.ghr));
        end
    end
    initial begin
        cur_f = nop(32'h0);
        drive();
        step(nop(32'h0), 0, 1);
        step(nop(32'h0), 0, 1);
        cmp("lit reset mispredict", 32'(b.mispredict_o), 32'h0);
        cmp("lit reset PHTwe", 32'(b.PHTwe_o), 32'h0);
        // branch predicted not-taken but taken
        run3(mk(32'h100, 0, 32'h0, 5'h3, BR, 1, 32'h80));
        cmp("lit A mispredict", 32'(b.mispredict_o), 32'h1);
        cmp("lit A redirect", b.redirect_pc_o, 32'h80);
        cmp("lit A BTB_we", 32'(b.BTB_we_o), 32'h1);
        cmp("lit A BTB addr", 32'(b.BTBwriteaddress_o), 32'h0);
        cmp("lit A PHTinc", 32'(b.PHTincrement_o), 32'h1);
        cmp("lit A GHRreset", 32'(b.GHRreset_o), 32'h1);
        step(nop(32'h1008), 0, 0);
        cmp("lit A flushed", 32'(b.mispredict_o), 32'h0);
        // branch predicted correctly taken
        run3(mk(32'h104, 1, 32'h80, 5'h7, BR, 1, 32'h80));
        cmp("lit B mispredict", 32'(b.mispredict_o), 32'h0);
        cmp("lit B BTB_we", 32'(b.BTB_we_o), 32'h0);
        cmp("lit B PHTwe", 32'(b.PHTwe_o), 32'h1);
        // branch predicted taken but not taken
        run3(mk(32'h200, 1, 32'h300, 5'h1f, BR, 0, 32'h300));
        cmp("lit C mispredict", 32'(b.mispredict_o), 32'h1);
        cmp("lit C redirect", b.redirect_pc_o, 32'h204);
        cmp("lit C BTB_we", 32'(b.BTB_we_o), 32'h0);
        cmp("lit C PHTinc", 32'(b.PHTincrement_o), 32'h0);
        // jal with stale target
        run3(mk(32'h40, 1, 32'h10, 5'h2, JAL, 0, 32'h20));
        cmp("lit D redirect", b.redirect_pc_o, 32'h20);
        cmp("lit D BTB data", b.BTBwritedata_o, 32'h20);
        cmp("lit D BTB addr", 32'(b.BTBwriteaddress_o), 32'h10);
        cmp("lit D PHTwe", 32'(b.PHTwe_o), 32'h0);
        cmp("lit D GHRreset", 32'(b.GHRreset_o), 32'h0);
        // assorted patterns: ALU predicted taken, good jalr, wrong-target branch, wrap-around
        run3(mk(32'h60, 1, 32'h500, 5'h4, ALU, 1, 32'h0));
        cmp("lit ALU redirect", b.redirect_pc_o, 32'h64);
        run3(mk(32'h80, 1, 32'h44, 5'h5, JALR, 0, 32'h44));
        run3(mk(32'h120, 1, 32'h400, 5'h9, BR, 1, 32'h440));
        run3(mk(32'hFFFFFFFC, 1, 32'h8, 5'h11, BR, 0, 32'h8));
        cmp("lit wrap mispredict", 32'(b.mispredict_o), 32'h1);
        run3(mk(32'h130, 0, 32'h0, 5'h12, BR, 0, 32'h50));
        // two-cycle stall: E bubbles, D released unchanged
        step(mk(32'h300, 0, 32'h0, 5'h6, BR, 0, 32'h340), 0, 0);
        step(nop(32'h304), 1, 0);
        step(nop(32'h304), 1, 0);
        cmp("lit stall bubble1", 32'(b.PHTwe_o), 32'h0);
        step(nop(32'h304), 0, 0);
        cmp("lit stall bubble2", 32'(b.PHTwe_o), 32'h0);
        step(nop(32'h308), 0, 0);
        cmp("lit stall release PHTwe", 32'(b.PHTwe_o), 32'h1);
        cmp("lit stall release pc", b.pc_update_o, 32'h300);
        // mispredict while decode is stalled clears D
        step(mk(32'h500, 1, 32'h600, 5'h0, ALU, 0, 32'h0), 0, 0);
        step(mk(32'h504, 0, 32'h0, 5'h8, BR, 0, 32'h0), 0, 0);
        step(nop(32'h508), 1, 0);
        cmp("lit stall mispredict", 32'(b.mispredict_o), 32'h1);
        step(nop(32'h508), 0, 0);
        step(nop(32'h50c), 0, 0);
        cmp("lit stalled D dropped", 32'(b.PHTwe_o), 32'h0);
        // reset with a mispredicting branch in E
        step(mk(32'h700, 0, 32'h0, 5'ha, BR, 1, 32'h7f0), 0, 0);
        step(nop(32'h704), 0, 0);
        step(nop(32'h708), 0, 1);
        cmp("lit pre-reset mispredict", 32'(b.mispredict_o), 32'h1);
        step(nop(32'h70c), 0, 0);
        cmp("lit post-reset mispredict", 32'(b.mispredict_o), 32'h0);
        cmp("lit post-reset BTB_we", 32'(b.BTB_we_o), 32'h0);
        cmp("lit post-reset PHTwe", 32'(b.PHTwe_o), 32'h0);
        cmp("lit post-reset redirect", b.redirect_pc_o, 32'h0);
        step(nop(32'h710), 0, 0);
        step(nop(32'h714), 0, 0);
`ifdef BRANCH_STATS_EN
        cmp("stat_branches_o", stat_b, 32'(m_nb));
        cmp("stat_mispredicts_o", stat_m, 32'(m_nm));
`endif
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
